dea_frame_rx: RTL and testbench

- Upstream stage of the DEA encryption engine; sits between UART_Receiver and the XOR encrypt/transmit logic.
- Parses one length-prefixed frame from the receiver's Ready/Ack byte stream: [data_len][data bytes][key_len][key bytes].
- Stores the data and key bytes in internal buffers and exposes them through registered read ports.
- Raises frame_valid when a complete frame is held, and holds it until the consumer releases the buffers with frame_clear.

---
 rtl/dea_pkg.sv | 22 ++
 rtl/dea_byte_ram.sv | 37 +++
 rtl/dea_frame_rx.sv | 178 +++++++++++++++++
 tb/tb_dea_frame_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/dea_pkg.sv
// Shared types and constants for the DEA encryption engine front end.
package dea_pkg;

    localparam int unsigned DEF_MAX_DATA       = 100;
    localparam int unsigned DEF_MAX_KEY        = 4;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 1000000;

    typedef enum logic [2:0] {
        S_DLEN = 3'd0,
        S_DATA = 3'd1,
        S_KLEN = 3'd2,
        S_KEY  = 3'd3,
        S_FULL = 3'd4,
        S_ERR  = 3'd5
    } rxState_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_DLEN    = 2'd1;
    localparam logic [1:0] ERR_KLEN    = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/dea_byte_ram.sv
// Single-write, single-registered-read byte buffer; out-of-range reads return 0.
module dea_byte_ram #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          Clk_100M,
    input  logic          Reset,
    input  logic          wrEn,
    input  logic [AW-1:0] wrAddr,
    input  logic [7:0]    wrData,
    input  logic [AW-1:0] rdAddr,
    output logic [7:0]    rdData
);

    logic [7:0] mem [DEPTH];
    logic       rdInRange;

    assign rdInRange = (32'(rdAddr) < DEPTH);

    // Storage is deliberately not reset
    always_ff @(posedge Clk_100M) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            rdData <= 8'd0;
        end else if (rdInRange) begin
            rdData <= mem[rdAddr];
        end else begin
            rdData <= 8'd0;
        end
    end

endmodule

// File: rtl/dea_frame_rx.sv
// Length-prefixed frame parser: [data_len][data][key_len][key] into data/key buffers.
// Optional inter-byte timeout enabled with `define DEA_FRAME_RX_TIMEOUT_EN.
module dea_frame_rx
    import dea_pkg::*;
#(
    parameter int unsigned MAX_DATA       = DEF_MAX_DATA,
    parameter int unsigned MAX_KEY        = DEF_MAX_KEY,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic       Clk_100M,
    input  logic       Reset,
    input  logic [7:0] Rx_Data,
    input  logic       Rx_Ready,
    output logic       Rx_Ack,
    input  logic [6:0] data_rd_addr,
    output logic [7:0] data_rd_byte,
    input  logic [1:0] key_rd_addr,
    output logic [7:0] key_rd_byte,
    output logic [7:0] data_len,
    output logic [7:0] key_len,
    output logic       frame_valid,
    output logic       frame_err,
    output logic [1:0] err_code,
    input  logic       frame_clear
);

    rxState_t   state, stateNxt;
    logic [7:0] cnt, cntNxt;
    logic [7:0] dataLenNxt, keyLenNxt;
    logic [1:0] errCodeNxt;
    logic       ackNxt;
    logic       accept;
    logic       dataWe, keyWe;

`ifdef DEA_FRAME_RX_TIMEOUT_EN
    logic [31:0] idleCnt, idleNxt;
`endif

    // One byte per Ready pulse; S_FULL applies backpressure by withholding the ack
    assign accept = Rx_Ready && !Rx_Ack && (state != S_FULL);

    always_ff @(posedge Clk_100M) begin
        if (Reset) begin
            state       <= S_DLEN;
            cnt         <= 8'd0;
            Rx_Ack      <= 1'b0;
            data_len    <= 8'd0;
            key_len     <= 8'd0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            err_code    <= ERR_NONE;
`ifdef DEA_FRAME_RX_TIMEOUT_EN
            idleCnt     <= 32'd0;
`endif
        end else begin
            state       <= stateNxt;
            cnt         <= cntNxt;
            Rx_Ack      <= ackNxt;
            data_len    <= dataLenNxt;
            key_len     <= keyLenNxt;
            frame_valid <= (stateNxt == S_FULL);
            frame_err   <= (stateNxt == S_ERR);
            err_code    <= errCodeNxt;
`ifdef DEA_FRAME_RX_TIMEOUT_EN
            idleCnt     <= idleNxt;
`endif
        end
    end

    always_comb begin
        stateNxt   = state;
        cntNxt     = cnt;
        dataLenNxt = data_len;
        keyLenNxt  = key_len;
        errCodeNxt = err_code;
        dataWe     = 1'b0;
        keyWe      = 1'b0;
        ackNxt     = accept || (Rx_Ack && Rx_Ready);
`ifdef DEA_FRAME_RX_TIMEOUT_EN
        idleNxt    = 32'd0;
`endif

        case (state)
            S_DLEN, S_DATA, S_KLEN, S_KEY: begin
                // Clear outranks a coincident byte: it is acked but dropped
                if (frame_clear) begin
                    stateNxt = S_DLEN;
                end else if (accept) begin
                    case (state)
                        S_DLEN: begin
                            if ((Rx_Data == 8'd0) || (32'(Rx_Data) > MAX_DATA)) begin
                                stateNxt   = S_ERR;
                                errCodeNxt = ERR_DLEN;
                            end else begin
                                dataLenNxt = Rx_Data;
                                cntNxt     = 8'd0;
                                stateNxt   = S_DATA;
                            end
                        end
                        S_DATA: begin
                            dataWe = 1'b1;
                            cntNxt = cnt + 8'd1;
                            if (cnt == data_len - 8'd1) begin
                                stateNxt = S_KLEN;
                            end
                        end
                        S_KLEN: begin
                            if ((Rx_Data == 8'd0) || (32'(Rx_Data) > MAX_KEY)) begin
                                stateNxt   = S_ERR;
                                errCodeNxt = ERR_KLEN;
                            end else begin
                                keyLenNxt = Rx_Data;
                                cntNxt    = 8'd0;
                                stateNxt  = S_KEY;
                            end
                        end
                        S_KEY: begin
                            keyWe  = 1'b1;
                            cntNxt = cnt + 8'd1;
                            if (cnt == key_len - 8'd1) begin
                                stateNxt = S_FULL;
                            end
                        end
                        default: stateNxt = S_DLEN;
                    endcase
                end
`ifdef DEA_FRAME_RX_TIMEOUT_EN
                else if (state != S_DLEN) begin
                    idleNxt = idleCnt + 32'd1;
                    if (idleNxt >= TIMEOUT_CYCLES) begin
                        stateNxt   = S_ERR;
                        errCodeNxt = ERR_TIMEOUT;
                    end
                end
`endif
            end
            S_FULL: begin
                if (frame_clear) begin
                    stateNxt = S_DLEN;
                end
            end
            S_ERR: begin
                if (frame_clear) begin
                    stateNxt   = S_DLEN;
                    errCodeNxt = ERR_NONE;
                end
            end
            default: stateNxt = S_DLEN;
        endcase
    end

    dea_byte_ram #(
        .DEPTH (MAX_DATA),
        .AW    (7)
    ) u_data_ram (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .wrEn     (dataWe),
        .wrAddr   (7'(cnt)),
        .wrData   (Rx_Data),
        .rdAddr   (data_rd_addr),
        .rdData   (data_rd_byte)
    );

    dea_byte_ram #(
        .DEPTH (MAX_KEY),
        .AW    (2)
    ) u_key_ram (
        .Clk_100M (Clk_100M),
        .Reset    (Reset),
        .wrEn     (keyWe),
        .wrAddr   (2'(cnt)),
        .wrData   (Rx_Data),
        .rdAddr   (key_rd_addr),
        .rdData   (key_rd_byte)
    );

endmodule

// File: tb/tb_dea_frame_rx.sv
// Directed bench for dea_frame_rx: parsing, backpressure, errors, reset and clear races.
module tb_dea_frame_rx;

    logic       Clk_100M = 1'b0;
    logic       Reset;
    logic [7:0] Rx_Data;
    logic       Rx_Ready;
    logic       Rx_Ack;
    logic [6:0] data_rd_addr;
    logic [7:0] data_rd_byte;
    logic [1:0] key_rd_addr;
    logic [7:0] key_rd_byte;
    logic [7:0] data_len;
    logic [7:0] key_len;
    logic       frame_valid;
    logic       frame_err;
    logic [1:0] err_code;
    logic       frame_clear;

    int checkCnt = 0;
    int errCnt   = 0;

    always #5 Clk_100M = ~Clk_100M;

    dea_frame_rx #(.TIMEOUT_CYCLES(50)) dut (
        .Clk_100M     (Clk_100M),
        .Reset        (Reset),
        .Rx_Data      (Rx_Data),
        .Rx_Ready     (Rx_Ready),
        .Rx_Ack       (Rx_Ack),
        .data_rd_addr (data_rd_addr),
        .data_rd_byte (data_rd_byte),
        .key_rd_addr  (key_rd_addr),
        .key_rd_byte  (key_rd_byte),
        .data_len     (data_len),
        .key_len      (key_len),
        .frame_valid  (frame_valid),
        .frame_err    (frame_err),
        .err_code     (err_code),
        .frame_clear  (frame_clear)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCnt++;
        if (got !== exp) begin
            errCnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] b);
        logic gotAck;
        gotAck = 1'b0;
        @(negedge Clk_100M);
        Rx_Data  = b;
        Rx_Ready = 1'b1;
        for (int i = 0; i < 20 && !gotAck; i++) begin
            @(negedge Clk_100M);
            if (Rx_Ack) gotAck = 1'b1;
        end
        checkVal("byte_acked", 32'(gotAck), 32'd1);
        Rx_Ready = 1'b0;
    endtask

    task automatic pulseClear();
        @(negedge Clk_100M);
        frame_clear = 1'b1;
        @(negedge Clk_100M);
        frame_clear = 1'b0;
    endtask

    task automatic readData(input logic [6:0] a, output logic [7:0] v);
        @(negedge Clk_100M);
        data_rd_addr = a;
        @(negedge Clk_100M);
        v = data_rd_byte;
    endtask

    task automatic readKey(input logic [1:0] a, output logic [7:0] v);
        @(negedge Clk_100M);
        key_rd_addr = a;
        @(negedge Clk_100M);
        v = key_rd_byte;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;

        Reset        = 1'b1;
        Rx_Data      = 8'd0;
        Rx_Ready     = 1'b0;
        frame_clear  = 1'b0;
        data_rd_addr = 7'd0;
        key_rd_addr  = 2'd0;
        repeat (3) @(negedge Clk_100M);
        checkVal("rst_ack", 32'(Rx_Ack), 32'd0);
        checkVal("rst_valid", 32'(frame_valid), 32'd0);
        checkVal("rst_err", 32'(frame_err), 32'd0);
        checkVal("rst_code", 32'(err_code), 32'd0);
        checkVal("rst_dlen", 32'(data_len), 32'd0);
        checkVal("rst_klen", 32'(key_len), 32'd0);
        checkVal("rst_drd", 32'(data_rd_byte), 32'd0);
        checkVal("rst_krd", 32'(key_rd_byte), 32'd0);
        Reset = 1'b0;

        // Basic frame
        sendByte(8'h03); sendByte(8'h41); sendByte(8'h42); sendByte(8'h43);
        sendByte(8'h02); sendByte(8'h0F);
        checkVal("f1_not_yet", 32'(frame_valid), 32'd0);
        sendByte(8'hF0);
        checkVal("f1_valid", 32'(frame_valid), 32'd1);
        checkVal("f1_dlen", 32'(data_len), 32'd3);
        checkVal("f1_klen", 32'(key_len), 32'd2);
        readData(7'd0, v); checkVal("f1_d0", 32'(v), 32'h41);
        readData(7'd1, v); checkVal("f1_d1", 32'(v), 32'h42);
        readData(7'd2, v); checkVal("f1_d2", 32'(v), 32'h43);
        readKey(2'd0, v);  checkVal("f1_k0", 32'(v), 32'h0F);
        readKey(2'd1, v);  checkVal("f1_k1", 32'(v), 32'hF0);
        readData(7'd100, v); checkVal("f1_oob100", 32'(v), 32'd0);
        readData(7'd127, v); checkVal("f1_oob127", 32'(v), 32'd0);

        // Backpressure while full, then clear admits the waiting byte
        @(negedge Clk_100M);
        Rx_Data  = 8'h02;
        Rx_Ready = 1'b1;
        repeat (3) @(negedge Clk_100M);
        checkVal("bp_ack", 32'(Rx_Ack), 32'd0);
        checkVal("bp_valid", 32'(frame_valid), 32'd1);
        frame_clear = 1'b1;
        @(negedge Clk_100M);
        frame_clear = 1'b0;
        checkVal("bp_clr_valid", 32'(frame_valid), 32'd0);
        checkVal("bp_clr_ack", 32'(Rx_Ack), 32'd0);
        @(negedge Clk_100M);
        checkVal("bp_ack_after", 32'(Rx_Ack), 32'd1);
        checkVal("bp_dlen", 32'(data_len), 32'd2);
        Rx_Ready = 1'b0;
        @(negedge Clk_100M);
        checkVal("bp_ack_drop", 32'(Rx_Ack), 32'd0);
        pulseClear();

        // Bad data length: zero and over maximum
        sendByte(8'h00);
        checkVal("e0_err", 32'(frame_err), 32'd1);
        checkVal("e0_code", 32'(err_code), 32'd1);
        sendByte(8'h33);
        checkVal("e0_sticky", 32'(frame_err), 32'd1);
        pulseClear();
        checkVal("e0_clr_err", 32'(frame_err), 32'd0);
        checkVal("e0_clr_code", 32'(err_code), 32'd0);
        sendByte(8'h65);
        checkVal("e65_err", 32'(frame_err), 32'd1);
        checkVal("e65_code", 32'(err_code), 32'd1);
        pulseClear();

        // Bad key length
        sendByte(8'h01); sendByte(8'h55);
        checkVal("ek_pre", 32'(frame_err), 32'd0);
        sendByte(8'h05);
        checkVal("ek_err", 32'(frame_err), 32'd1);
        checkVal("ek_code", 32'(err_code), 32'd2);
        pulseClear();
        checkVal("ek_clr_code", 32'(err_code), 32'd0);

        // Reset mid-frame discards partial content
        sendByte(8'h04); sendByte(8'h11); sendByte(8'h22);
        @(negedge Clk_100M);
        Reset = 1'b1;
        @(negedge Clk_100M);
        Reset = 1'b0;
        checkVal("mr_ack", 32'(Rx_Ack), 32'd0);
        checkVal("mr_dlen", 32'(data_len), 32'd0);
        sendByte(8'h01); sendByte(8'hAA); sendByte(8'h01); sendByte(8'hBB);
        checkVal("mr_valid", 32'(frame_valid), 32'd1);
        checkVal("mr_dlen2", 32'(data_len), 32'd1);
        checkVal("mr_klen2", 32'(key_len), 32'd1);
        readData(7'd0, v); checkVal("mr_d0", 32'(v), 32'hAA);
        readKey(2'd0, v);  checkVal("mr_k0", 32'(v), 32'hBB);
        pulseClear();

        // Clear coincident with an accepted byte: acked, dropped
        @(negedge Clk_100M);
        Rx_Data     = 8'h05;
        Rx_Ready    = 1'b1;
        frame_clear = 1'b1;
        @(negedge Clk_100M);
        frame_clear = 1'b0;
        checkVal("cc_ack", 32'(Rx_Ack), 32'd1);
        checkVal("cc_dlen", 32'(data_len), 32'd1);
        Rx_Ready = 1'b0;
        sendByte(8'h01); sendByte(8'h77); sendByte(8'h01); sendByte(8'h88);
        checkVal("cc_valid", 32'(frame_valid), 32'd1);
        readData(7'd0, v); checkVal("cc_d0", 32'(v), 32'h77);
        readKey(2'd0, v);  checkVal("cc_k0", 32'(v), 32'h88);
        pulseClear();

        // Maximum-size frame
        sendByte(8'd100);
        for (int k = 0; k < 100; k++) sendByte(8'(k * 3 + 1));
        checkVal("mx_not_yet", 32'(frame_valid), 32'd0);
        sendByte(8'd4);
        for (int k = 0; k < 4; k++) sendByte(8'(8'hC0 + k));
        checkVal("mx_valid", 32'(frame_valid), 32'd1);
        checkVal("mx_dlen", 32'(data_len), 32'd100);
        checkVal("mx_klen", 32'(key_len), 32'd4);
        readData(7'd0, v);  checkVal("mx_d0", 32'(v), 32'h01);
        readData(7'd99, v); checkVal("mx_d99", 32'(v), 32'(8'(99 * 3 + 1)));
        readData(7'd100, v); checkVal("mx_oob", 32'(v), 32'd0);
        readKey(2'd3, v);   checkVal("mx_k3", 32'(v), 32'hC3);
        pulseClear();
        checkVal("mx_clr", 32'(frame_valid), 32'd0);

`ifdef DEA_FRAME_RX_TIMEOUT_EN
        sendByte(8'h02); sendByte(8'h11);
        for (int i = 0; i < 80 && !frame_err; i++) @(negedge Clk_100M);
        checkVal("to_err", 32'(frame_err), 32'd1);
        checkVal("to_code", 32'(err_code), 32'd3);
        pulseClear();
`endif

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
